scr1_tb_cmd_capture: RTL and testbench
======================================

# scr1_tb_cmd_capture

Synthesizable instruction-match capture stage for the SCR1 AHB testbench. It watches the IFU→IDU instruction handshake and, on every accepted instruction matching a programmable pattern (default: RV32I SUB), snapshots PC, mstatus, mtvec and mcycle into a small FIFO. The FIFO drains over a valid/ready record interface to the downstream CSR logging monitor, so logging is decoupled from the core's pipeline timing. Overflows are counted, never stall the core.

## Interface
- `MATCH_MASK`, 32'hFE00707F, instruction bits compared (funct7, funct3, opcode)
- `MATCH_VAL`, 32'h40000033, required value under mask (SUB)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `XLEN`, 32, CSR/PC width
- `CNT_W`, 64, mcycle width
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, synchronous, active-low
- `instr_vld_i`  in  1  IFU→IDU instruction valid
- `instr_rdy_i`  in  1  IDU accepts instruction
- `instr_i`  in  32  instruction word
- `pc_i`  in  XLEN  PC of `instr_i`
- `mstatus_i`, `mtvec_i`  in  XLEN  current CSR values
- `mcycle_i`  in  CNT_W  current cycle counter
- `rec_vld_o`  out  1  head record valid
- `rec_rdy_i`  in  1  consumer accepts head record
- `rec_pc_o`, `rec_mstatus_o`, `rec_mtvec_o`  out  XLEN  head record fields
- `rec_mcycle_o`  out  CNT_W  head record mcycle
- `rec_seq_o`  out  16  match sequence number of head record
- `drop_cnt_o`  out  16  dropped matches, saturating
- `ovf_o`  out  1  sticky: at least one drop since reset

## Operation
- match = `instr_vld_i & instr_rdy_i & ((instr_i & MATCH_MASK) == MATCH_VAL)`; no capture without the accept handshake.
- push = match & (not full | pop); pop = `rec_vld_o & rec_rdy_i`.
- On push: write {pc_i, mstatus_i, mtvec_i, mcycle_i, seq} sampled in the match cycle at write pointer.
- `seq`: 16-bit counter, increments on every match (pushed or dropped), wraps 0xFFFF→0x0000; record stores pre-increment value. Gaps in `rec_seq_o` reveal drops.
- Drop = match & full & !pop: `drop_cnt_o` += 1, saturating at 0xFFFF; `ovf_o` set, cleared only by reset.
- FIFO: write/read pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits. full = (count == DEPTH), empty = (count == 0).
- Output is first-word-fall-through: `rec_*_o` driven from head entry; `rec_vld_o` = !empty. Record fields unspecified when `rec_vld_o`=0.
- Simultaneous push & pop: count unchanged; allowed when full (slot freed same cycle) and when count==1.
- Pop when empty has no effect.
- Reset (any cycle, including mid-stream): pointers, count, seq, drop_cnt, ovf = 0; `rec_vld_o`=0 next cycle; in-flight records discarded.

## Timing
- Reset values: `rec_vld_o`=0, `drop_cnt_o`=0, `ovf_o`=0, `rec_seq_o`=0 (storage not reset; reset-value of record fields irrelevant while invalid).
- Capture latency: match in cycle N → `rec_vld_o`=1 in N+1 with that record at head (FIFO empty before).
- Throughput: one push and one pop per cycle.
- `drop_cnt_o`/`ovf_o` update in cycle after the dropping match.
- Consumer may hold `rec_rdy_i` low indefinitely; head record stays stable while `rec_vld_o`=1 and no pop.
- No combinational path from `rec_rdy_i` to `rec_vld_o`; input-to-output paths are all registered.

## Test plan
- Single SUB: instr_i=0x40B50533 (sub a0,a0,a1), pc_i=0x200, vld=rdy=1 one cycle, rec_rdy_i=1 → next cycle rec_vld_o=1, rec_pc_o=0x200, rec_seq_o=0; following cycle rec_vld_o=0.
- Non-matches: ADD 0x00B50533, SUB with vld=1/rdy=0, SUB with vld=0 → no record, seq stays 0.
- Overflow: rec_rdy_i=0, 6 consecutive SUBs, DEPTH=4 → 4 records seq 0..3, drop_cnt_o=2, ovf_o=1; then drain → seqs 0,1,2,3 in order, next SUB gets seq 6.
- Full push+pop: FIFO full, SUB with rec_rdy_i=1 same cycle → no drop, count stays 4, new record at tail.
- Back-to-back stream: 100 SUBs every cycle with rec_rdy_i=1 → 100 records, contiguous seq, mcycle fields matching capture cycles, drop_cnt_o=0.
- Reset mid-stream: rst_n=0 one cycle with 3 records queued → rec_vld_o=0, drop_cnt_o=0, ovf_o=0; next SUB gets seq 0.

Source files
------------

// File: rtl/scr1_tb_cmd_capture.sv
// Instruction-match capture stage: snapshots PC/CSRs/mcycle of every accepted
// matching instruction into a first-word-fall-through FIFO drained by a logging monitor.
module scr1_tb_cmd_capture #(
    parameter logic [31:0] MATCH_MASK = 32'hFE00707F,
    parameter logic [31:0] MATCH_VAL  = 32'h40000033,
    parameter int          DEPTH      = 4,
    parameter int          XLEN       = 32,
    parameter int          CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_vld_i,
    input  logic             instr_rdy_i,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  mstatus_i,
    input  logic [XLEN-1:0]  mtvec_i,
    input  logic [CNT_W-1:0] mcycle_i,
    output logic             rec_vld_o,
    input  logic             rec_rdy_i,
    output logic [XLEN-1:0]  rec_pc_o,
    output logic [XLEN-1:0]  rec_mstatus_o,
    output logic [XLEN-1:0]  rec_mtvec_o,
    output logic [CNT_W-1:0] rec_mcycle_o,
    output logic [15:0]      rec_seq_o,
    output logic [15:0]      drop_cnt_o,
    output logic             ovf_o
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [XLEN-1:0]  pc_mem_q      [DEPTH];
    logic [XLEN-1:0]  mstatus_mem_q [DEPTH];
    logic [XLEN-1:0]  mtvec_mem_q   [DEPTH];
    logic [CNT_W-1:0] mcycle_mem_q  [DEPTH];
    logic [15:0]      seq_mem_q     [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d;

    logic match, full, empty, pop, push, drop;

    assign match = instr_vld_i & instr_rdy_i & ((instr_i & MATCH_MASK) == MATCH_VAL);
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = rec_vld_o & rec_rdy_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = match & (~full | pop);
    assign drop  = match & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (match) seq_d = seq_q + 16'd1;
        if (drop) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Record storage is deliberately not reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]      <= pc_i;
            mstatus_mem_q[wr_ptr_q] <= mstatus_i;
            mtvec_mem_q[wr_ptr_q]   <= mtvec_i;
            mcycle_mem_q[wr_ptr_q]  <= mcycle_i;
            seq_mem_q[wr_ptr_q]     <= seq_q;
        end
    end

    assign rec_vld_o     = ~empty;
    assign rec_pc_o      = pc_mem_q[rd_ptr_q];
    assign rec_mstatus_o = mstatus_mem_q[rd_ptr_q];
    assign rec_mtvec_o   = mtvec_mem_q[rd_ptr_q];
    assign rec_mcycle_o  = mcycle_mem_q[rd_ptr_q];
    assign rec_seq_o     = empty ? 16'd0 : seq_mem_q[rd_ptr_q];
    assign drop_cnt_o    = drop_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_scr1_tb_cmd_capture.sv
// Bench for scr1_tb_cmd_capture: directed scenarios plus random traffic against
// a queue-based reference model compared on every falling edge.
module tb_scr1_tb_cmd_capture;

    localparam logic [31:0] MASK  = 32'hFE00707F;
    localparam logic [31:0] VAL   = 32'h40000033;
    localparam int          DEPTH = 4;
    localparam logic [31:0] SUB   = 32'h40B50533;
    localparam logic [31:0] ADD   = 32'h00B50533;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_vld_i, instr_rdy_i, rec_rdy_i;
    logic [31:0] instr_i, pc_i, mstatus_i, mtvec_i;
    logic [63:0] mcycle_i = 64'hABCD_0000_0000_0000;
    logic        rec_vld_o, ovf_o;
    logic [31:0] rec_pc_o, rec_mstatus_o, rec_mtvec_o;
    logic [63:0] rec_mcycle_o;
    logic [15:0] rec_seq_o, drop_cnt_o;

    int passCnt = 0;
    int totalCnt = 0;
    bit chkEn = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [63:0] mcycle;
        logic [15:0] seq;
    } rec_t;

    rec_t        modelQ[$];
    logic [15:0] modelSeq;
    int          modelDrop;
    bit          modelOvf;

    scr1_tb_cmd_capture #(
        .MATCH_MASK(MASK), .MATCH_VAL(VAL), .DEPTH(DEPTH), .XLEN(32), .CNT_W(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_vld_i(instr_vld_i), .instr_rdy_i(instr_rdy_i), .instr_i(instr_i),
        .pc_i(pc_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mcycle_i(mcycle_i),
        .rec_vld_o(rec_vld_o), .rec_rdy_i(rec_rdy_i),
        .rec_pc_o(rec_pc_o), .rec_mstatus_o(rec_mstatus_o), .rec_mtvec_o(rec_mtvec_o),
        .rec_mcycle_o(rec_mcycle_o), .rec_seq_o(rec_seq_o),
        .drop_cnt_o(drop_cnt_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mcycle_i <= mcycle_i + 64'd1;

    task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            passCnt++;
    endtask

    // Reference model: a bounded queue of records; the pop is applied before the
    // push so a full queue accepts a match whenever the consumer takes the head.
    always @(posedge clk) begin
        rec_t r;
        if (!rst_n) begin
            modelQ.delete();
            modelSeq  = 16'd0;
            modelDrop = 0;
            modelOvf  = 1'b0;
        end else begin
            if (modelQ.size() > 0 && rec_rdy_i) void'(modelQ.pop_front());
            if (instr_vld_i && instr_rdy_i && ((instr_i & MASK) == VAL)) begin
                if (modelQ.size() < DEPTH) begin
                    r.pc = pc_i; r.mstatus = mstatus_i; r.mtvec = mtvec_i;
                    r.mcycle = mcycle_i; r.seq = modelSeq;
                    modelQ.push_back(r);
                end else begin
                    if (modelDrop < 65535) modelDrop++;
                    modelOvf = 1'b1;
                end
                modelSeq = modelSeq + 16'd1;
            end
        end
    end

    // Every cycle the DUT must agree with the model.
    always @(negedge clk) begin
        if (chkEn) begin
            expectEq("rec_vld", rec_vld_o, modelQ.size() != 0);
            expectEq("drop_cnt", drop_cnt_o, modelDrop);
            expectEq("ovf", ovf_o, modelOvf);
            if (modelQ.size() != 0) begin
                expectEq("rec_pc", rec_pc_o, modelQ[0].pc);
                expectEq("rec_mstatus", rec_mstatus_o, modelQ[0].mstatus);
                expectEq("rec_mtvec", rec_mtvec_o, modelQ[0].mtvec);
                expectEq("rec_mcycle", rec_mcycle_o, modelQ[0].mcycle);
                expectEq("rec_seq", rec_seq_o, modelQ[0].seq);
            end
        end
    end

    // Drive one cycle of inputs, then return just after the next rising edge.
    task automatic applyStimulus(input logic rstN, input logic vld, input logic rdy,
                                 input logic [31:0] instr, input logic [31:0] pc,
                                 input logic recRdy);
        rst_n       = rstN;
        instr_vld_i = vld;
        instr_rdy_i = rdy;
        instr_i     = instr;
        pc_i        = pc;
        mstatus_i   = $urandom;
        mtvec_i     = $urandom;
        rec_rdy_i   = recRdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        expectEq(name, act, exp);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chkEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset_vld", rec_vld_o, 0);
        checkOutput("reset_drop", drop_cnt_o, 0);
        checkOutput("reset_ovf", ovf_o, 0);
        checkOutput("reset_seq", rec_seq_o, 0);

        applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h200, 1'b1);
        checkOutput("single_vld", rec_vld_o, 1);
        checkOutput("single_pc", rec_pc_o, 32'h200);
        checkOutput("single_seq", rec_seq_o, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("single_gone", rec_vld_o, 0);

        applyStimulus(1'b1, 1'b1, 1'b1, ADD, 32'h204, 1'b1);
        checkOutput("add_novld", rec_vld_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, SUB, 32'h208, 1'b1);
        checkOutput("noaccept_novld", rec_vld_o, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, SUB, 32'h20C, 1'b1);
        checkOutput("novalid_novld", rec_vld_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h210, 1'b0);
        checkOutput("after_nonmatch_seq", rec_seq_o, 1);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h300 + 32'(i * 4), 1'b0);
        checkOutput("ovf_drop", drop_cnt_o, 2);
        checkOutput("ovf_flag", ovf_o, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_seq", rec_seq_o, 16'(i));
            checkOutput("drain_pc", rec_pc_o, 32'h300 + 32'(i * 4));
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        checkOutput("drained_vld", rec_vld_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h400, 1'b0);
        checkOutput("post_ovf_seq", rec_seq_o, 6);

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h404 + 32'(i * 4), 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h500, 1'b1);
        checkOutput("fullpp_drop", drop_cnt_o, 2);
        checkOutput("fullpp_head", rec_seq_o, 7);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fullpp_seq", rec_seq_o, 16'(7 + i));
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        checkOutput("fullpp_tail_empty", rec_vld_o, 0);

        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h1000 + 32'(i * 4), 1'b1);
            checkOutput("stream_seq", rec_seq_o, 16'(11 + i));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("stream_drop", drop_cnt_o, 2);

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h2000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("midrst_vld", rec_vld_o, 0);
        checkOutput("midrst_drop", drop_cnt_o, 0);
        checkOutput("midrst_ovf", ovf_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, SUB, 32'h2100, 1'b0);
        checkOutput("midrst_seq", rec_seq_o, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] instr;
            instr = ($urandom_range(1, 0) == 1) ? (VAL | ($urandom & ~MASK)) : $urandom;
            applyStimulus(($urandom_range(299, 0) != 0), ($urandom_range(3, 0) != 0),
                          ($urandom_range(3, 0) != 0), instr, $urandom,
                          ($urandom_range(2, 0) == 0));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
